// File: rtl/data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl
//   Single-port synchronous data memory for the MEM stage of the SimpleRISC
//   pipeline. Supports byte-lane writes, a read latency of 1 or 2 cycles, a
//   valid/ready request handshake, out-of-range address detection and an
//   optional post-reset clear sweep.
//
//   Optional feature macro: DM_CLEAR_EN
//     defined   : after reset, the block sweeps all DEPTH words to zero
//                 (rdy=0 for DEPTH cycles) before accepting requests.
//     undefined : no sweep; the block is ready one cycle after reset release
//                 and RAM contents stay undefined until written.
//
// Ports
//   clka    in   clock, all logic on the rising edge
//   rsta_n  in   asynchronous active-low reset (RAM contents are kept)
//   ena     in   request valid
//   wea     in   byte write enables; any bit set = write, all zero = read
//   addra   in   word address
//   dina    in   write data
//   rdy     out  block accepts a request this cycle
//   douta   out  read data, held between dvalid pulses
//   dvalid  out  one-cycle pulse qualifying douta/err
//   err     out  completing read addressed a word >= DEPTH
// -----------------------------------------------------------------------------
module data_mem_ctrl #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 7,
    parameter int unsigned DEPTH    = 2**ADDR_W,
    parameter int unsigned READ_LAT = 1
) (
    input  logic                  clka,
    input  logic                  rsta_n,
    input  logic                  ena,
    input  logic [DATA_W/8-1:0]   wea,
    input  logic [ADDR_W-1:0]     addra,
    input  logic [DATA_W-1:0]     dina,
    output logic                  rdy,
    output logic [DATA_W-1:0]     douta,
    output logic                  dvalid,
    output logic                  err
);

    localparam int unsigned      NB      = DATA_W / 8;
    localparam logic [ADDR_W:0]  DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic rdy_q;
    logic accept;
    logic in_range;
    logic wr_acc;
    logic rd_acc;
    logic [DATA_W-1:0] rd_data;

    // Read pipeline: stage READ_LAT-1 drives the outputs.
    logic [READ_LAT-1:0] pv_q;
    logic [READ_LAT-1:0] pe_q;
    logic [DATA_W-1:0]   pd_q [READ_LAT];

    assign in_range = ({1'b0, addra} < DEPTH_L);
    assign accept   = ena && rdy_q;
    assign wr_acc   = accept && (|wea) && in_range;
    assign rd_acc   = accept && !(|wea);
    assign rd_data  = in_range ? mem[addra] : '0;

`ifdef DM_CLEAR_EN
    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 1);

    state_t            state_q;
    logic [ADDR_W-1:0] clr_addr_q;
    logic              clr_we;

    // rdy is registered together with the state so it rises on the same
    // edge that writes the last sweep word.
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            state_q    <= CLEAR;
            clr_addr_q <= '0;
            rdy_q      <= 1'b0;
        end else begin
            case (state_q)
                CLEAR: begin
                    clr_addr_q <= clr_addr_q + 1'b1;
                    if (clr_addr_q == CLR_LAST) begin
                        state_q <= RUN;
                        rdy_q   <= 1'b1;
                    end
                end
                RUN: begin
                    rdy_q <= 1'b1;
                end
            endcase
        end
    end

    // Gated by rsta_n so the RAM is not touched while reset is held.
    assign clr_we = (state_q == CLEAR) && rsta_n;
`else
    typedef enum logic [0:0] {
        RUN = 1'b1
    } state_t;

    state_t state_q;

    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            state_q <= RUN;
            rdy_q   <= 1'b0;
        end else begin
            rdy_q <= (state_q == RUN);
        end
    end
`endif

    // RAM array: no reset. The sweep and request writes never coincide
    // because rdy is low for the whole sweep.
    always_ff @(posedge clka) begin
`ifdef DM_CLEAR_EN
        if (clr_we) begin
            mem[clr_addr_q] <= '0;
        end
`endif
        if (wr_acc) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (wea[i]) begin
                    mem[addra][8*i +: 8] <= dina[8*i +: 8];
                end
            end
        end
    end

    // Data in each stage only advances with a valid entry, so the last stage
    // holds douta between pulses; err travels with valid and is 0 otherwise.
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            pv_q <= '0;
            pe_q <= '0;
            for (int unsigned i = 0; i < READ_LAT; i++) begin
                pd_q[i] <= '0;
            end
        end else begin
            pv_q[0] <= rd_acc;
            pe_q[0] <= rd_acc && !in_range;
            if (rd_acc) begin
                pd_q[0] <= rd_data;
            end
            for (int unsigned i = 1; i < READ_LAT; i++) begin
                pv_q[i] <= pv_q[i-1];
                pe_q[i] <= pe_q[i-1];
                if (pv_q[i-1]) begin
                    pd_q[i] <= pd_q[i-1];
                end
            end
        end
    end

    assign rdy    = rdy_q;
    assign dvalid = pv_q[READ_LAT-1];
    assign err    = pe_q[READ_LAT-1];
    assign douta  = pd_q[READ_LAT-1];

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Parametrised successor to the pipeline's data memory: a single-port synchronous RAM with byte-lane write enables, configurable read latency (1 or 2 cycles), a valid/ready request handshake, out-of-range address detection and an optional post-reset clear sweep. It sits in the MEM stage of the SimpleRISC pipeline. It is fed from the EX/MEM register and returns load data to the MEM/WB register, qualified by `dvalid`.

## Interface
Parameters:
- `DATA_W`, 32, data width in bits; must be a multiple of 8
- `ADDR_W`, 7, word-address width
- `DEPTH`, 2**ADDR_W, number of implemented words; must satisfy DEPTH ≤ 2**ADDR_W
- `READ_LAT`, 1, read latency in cycles; legal values are 1 or 2

Ports:
- `clka`  in  1  single clock; all logic is rising-edge
- `rsta_n`  in  1  asynchronous, active-low reset
- `ena`  in  1  request valid
- `wea`  in  DATA_W/8  byte write enables; any bit set makes the request a write, all zero makes it a read
- `addra`  in  ADDR_W  word address
- `dina`  in  DATA_W  write data
- `rdy`  out  1  block can accept a request this cycle
- `douta`  out  DATA_W  read data
- `dvalid`  out  1  one-cycle pulse; `douta` and `err` are valid
- `err`  out  1  the completing read addressed a word ≥ DEPTH

## Operation
- A request is accepted on a rising edge with `ena && rdy`. When `rdy=0`, requests are dropped, not queued; the pipeline stalls on `!rdy`.
- Write: for each lane i with `wea[i]=1`, byte i of `mem[addra]` ← `dina[8i+7:8i]`. Lanes with `wea[i]=0` are untouched. No `dvalid` is produced.
- Read: `mem[addra]` is returned READ_LAT cycles after acceptance, with `dvalid=1` for one cycle.
- Read/write ordering: there is one port, so a request is either a read or a write. A read accepted in the cycle after a write to the same address returns the new data.
- Out of range (`addra ≥ DEPTH`):
  - write: ignored entirely, and no `err` is raised;
  - read: `douta=0` and `err=1` together with `dvalid`.
- `douta` holds its last value between `dvalid` pulses. `err` is 0 whenever `dvalid=0`.
- Read pipeline: a shift register of READ_LAT stages carrying {valid, err, data}. Throughput is one request per cycle.
- FSM states:
  - `CLEAR`: sweep counter `clr_addr` runs 0..DEPTH-1 and writes 0 to one word per cycle; `rdy=0`.
  - `RUN`: `rdy=1`.
  - Transitions: reset → `CLEAR` (or → `RUN` if the macro is absent). `CLEAR` → `RUN` on the cycle after `clr_addr == DEPTH-1` is written. `RUN` is terminal until reset.
- Reset mid-operation:
  - `rsta_n=0` flushes the read pipeline immediately.
  - In-flight reads are lost and never produce `dvalid`.
  - RAM contents are not reset by `rsta_n` itself.
  - The clear sweep restarts from address 0.

## Timing
- While `rsta_n=0`: `rdy=0`, `dvalid=0`, `err=0`, `douta=0`, FSM in `CLEAR`/`RUN` per configuration, `clr_addr=0`.
- Read accepted at edge N: `dvalid=1` during the cycle after edge N+READ_LAT-1. That means after edge N for READ_LAT=1, and after edge N+1 for READ_LAT=2.
- Write accepted at edge N: memory is updated at edge N.
- Clear sweep: takes exactly DEPTH cycles after the first edge with `rsta_n=1`. `rdy` rises after edge DEPTH.
- Without the clear sweep: `rdy` rises after the first edge with `rsta_n=1`.

## Configuration
- `DM_CLEAR_EN` defined: the FSM includes `CLEAR`, and every word reads 0 after the sweep.
- `DM_CLEAR_EN` undefined: `CLEAR` and `clr_addr` are removed; the FSM starts in `RUN`.
  - RAM initial contents are undefined (X in simulation).
  - Each word is defined only after it has been written.

## Test plan
- Reset, `DM_CLEAR_EN`, DEPTH=128: `rdy=0` for 128 cycles, then 1; reading addr 5 returns 0x00000000 with `dvalid` 1 cycle later.
- Write 0xDEADBEEF to addr 3 with `wea=4'hF`, then write 0x000000AA with `wea=4'b0001`, then read addr 3 → `douta=0xDEADBEAA`.
- READ_LAT=2, back-to-back reads of addrs 1,2,3 on consecutive cycles → three consecutive `dvalid` pulses with the matching data, starting 2 cycles after the first request.
- DEPTH=100, ADDR_W=7:
  - write 0x12345678 to addr 110 → memory unchanged, no `err`;
  - read addr 110 → `douta=0`, `err=1`, `dvalid=1`.
- Issue a read, then assert `rsta_n=0` before completion → no `dvalid` appears; after release the sweep restarts and `rdy=0` for DEPTH cycles.
- Drive `ena=1` with a write during `CLEAR` → the request is dropped; reading that address after `rdy=1` returns 0.
